serial_sub: RTL and testbench
=============================

# serial_sub

Parametrised multi-cycle subtractor that computes `a - b - bin` on WIDTH-bit unsigned operands, DIGIT bits per clock, LSB digit first. The borrow is carried between cycles in a register. It sits between operand producers and result consumers in the arithmetic datapath. Transfers use valid/ready handshakes on both sides. It is the sequential, width-generic successor to the single-bit full subtractor, with backpressure support and optional status flags.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 1.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and bin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- difference  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- borrow  out  1  borrow-out; 1 iff a < b + bin, unsigned.
- zero  out  1  difference == 0. Present only with SERIAL_SUB_FLAGS_EN.
- overflow  out  1  signed two's-complement overflow. Present only with SERIAL_SUB_FLAGS_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b and bin; clear the digit index; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, subtract digit k of a and b with the registered borrow, using bin for digit 0.
  - Write the digit result into difference[k*DIGIT +: DIGIT] and register the borrow-out.
  - After digit NDIG-1, go to DONE.
- DONE:
  - out_valid = 1; difference, borrow and flags are stable.
  - On out_ready, go to IDLE.
- in_valid outside IDLE is ignored, and the operands are not sampled.
- Arithmetic is unsigned modulo 2^WIDTH. borrow is the final registered borrow.
- DIGIT == WIDTH (NDIG = 1) is legal: one RUN cycle.

## Timing
- Reset (rst_n low at a clock edge):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - difference = 0, borrow = 0, zero = 0, overflow = 0.
  - Digit index and internal borrow are cleared.
- Reset mid-RUN or in DONE aborts the transaction; the pending result is discarded.
- Acceptance at edge T0. RUN occupies cycles T0+1 … T0+NDIG. out_valid rises after edge T0+NDIG, so latency is NDIG cycles.
- The result transfers at the edge where out_valid && out_ready. out_valid drops and in_ready rises after that edge.
- Minimum initiation interval is NDIG+2 cycles; there is no overlap between transactions.
- Outputs are held unchanged while out_valid && !out_ready, for any number of cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - zero and overflow ports exist and are registered on entry to DONE.
  - zero = (difference == 0).
  - overflow = (a[MSB] != b[MSB]) && (difference[MSB] != a[MSB]).
- Undefined: the ports are absent and no flag logic is built. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function that computes NDIG and the index width, $clog2(NDIG) with a minimum of 1.
- Sub-module sub_digit: a combinational DIGIT-bit ripple subtractor. Inputs x, y, bi; outputs d, bo. It is instantiated once in serial_sub.
- The top level contains the FSM, operand registers, digit index, borrow register and result register.

## Test plan
WIDTH=16, DIGIT=4 unless stated.
- a=0x1234, b=0x0234, bin=0 → difference=0x1000, borrow=0; out_valid exactly 4 cycles after acceptance.
- a=0x0000, b=0x0001, bin=0 → difference=0xFFFF, borrow=1. Same result with a=0x0005, b=0x0005, bin=1.
- Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands driven:
  - difference and borrow are held; in_ready stays 0; the new operands are not taken.
  - After out_ready rises, the next transaction is accepted in IDLE.
- Pulse rst_n=0 at the second RUN cycle → all outputs reset next cycle; no out_valid for the aborted operation; a fresh transaction then completes correctly.
- SERIAL_SUB_FLAGS_EN: a=0x8000, b=0x0001 → difference=0x7FFF, overflow=1, zero=0. Then a=b=0x00AA, bin=0 → zero=1, overflow=0.
- WIDTH=8, DIGIT=8: a=0x10, b=0x20 → difference=0xF0, borrow=1, out_valid 1 cycle after acceptance. Also run 1000 random operand sets, checked against a reference model.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helper for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    int ndig;
    int idx_w;
  } dig_cfg_t;

  // Digit count and digit-index width; the index is kept at least 1 bit wide.
  function automatic dig_cfg_t digit_cfg(input int width, input int digit);
    dig_cfg_t c;
    c.ndig  = width / digit;
    c.idx_w = (c.ndig > 1) ? $clog2(c.ndig) : 1;
    return c;
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: d = x - y - bi, bo = borrow out.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    bo = br[DIGIT];
  end

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor a - b - bin, LSB digit first, valid/ready on both sides.
// Optional zero/overflow status flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam dig_cfg_t CFG = digit_cfg(WIDTH, DIGIT);
  localparam int NDIG = CFG.ndig;
  localparam int IW   = CFG.idx_w;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
  logic             bin_q, brw_q;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] x, y, d;
  logic             bi, bo;

  assign x  = a_q[int'(idx)*DIGIT +: DIGIT];
  assign y  = b_q[int'(idx)*DIGIT +: DIGIT];
  assign bi = (idx == '0) ? bin_q : brw_q;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x (x),
    .y (y),
    .bi(bi),
    .d (d),
    .bo(bo)
  );

  always_comb begin
    diff_nx = diff_q;
    diff_nx[int'(idx)*DIGIT +: DIGIT] = d;
  end

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          bin_q <= bin;
          idx   <= '0;
        end
        RUN: begin
          diff_q <= diff_nx;
          brw_q  <= bo;
          idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // Flags are taken from the completed difference as it enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      zero     <= (diff_nx == '0);
      overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
    end
  end
`endif

  assign difference = diff_q;
  assign borrow     = brw_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub (16/4 and 8/8 instances).
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16, bin16, bo16;
  logic [15:0] a16, b16, d16;
  logic        iv8, ir8, ov8, or8, bin8, bo8;
  logic [7:0]  a8, b8, d8;
`ifdef SERIAL_SUB_FLAGS_EN
  logic        z16, v16, z8, v8;
`endif

  serial_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(or16),
    .difference(d16), .borrow(bo16)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(z16), .overflow(v16)
`endif
  );

  serial_sub #(.WIDTH(8), .DIGIT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
    .difference(d8), .borrow(bo8)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(z8), .overflow(v8)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait (bounded) for out_valid, report latency.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output int lat);
    iv16 = 1'b1; a16 = a; b16 = b; bin16 = bi;
    tick();
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish16();
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    chk("ov16_drop", ov16, 1'b0);
    chk("ir16_rise", ir16, 1'b1);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        bi;
    logic [15:0] d;
    logic        bo, z, v;
  } vec_t;

  vec_t vecs[10];
  int   lat;
  int   seen;
  logic [8:0] ref9;
  logic [7:0] ra, rb;
  logic       rbi;

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h00AA, 16'h00AA, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0; bin16 = 0;
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0; bin8 = 0;
    tick(); tick();

    chk("rst_in_ready", ir16, 1'b1);
    chk("rst_out_valid", ov16, 1'b0);
    chk("rst_difference", d16, 16'h0);
    chk("rst_borrow", bo16, 1'b0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("rst_zero", z16, 1'b0);
    chk("rst_overflow", v16, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      start16(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
      chk($sformatf("latency[%0d]", i), lat, 4);
      chk($sformatf("difference[%0d]", i), d16, vecs[i].d);
      chk($sformatf("borrow[%0d]", i), bo16, vecs[i].bo);
`ifdef SERIAL_SUB_FLAGS_EN
      chk($sformatf("zero[%0d]", i), z16, vecs[i].z);
      chk($sformatf("overflow[%0d]", i), v16, vecs[i].v);
`endif
      finish16();
    end

    // Backpressure in DONE while new operands are offered.
    start16(16'h1234, 16'h0234, 1'b0, lat);
    iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_out_valid", ov16, 1'b1);
      chk("hold_in_ready", ir16, 1'b0);
      chk("hold_difference", d16, 16'h1000);
      chk("hold_borrow", bo16, 1'b0);
    end
    iv16 = 1'b0;
    finish16();
    start16(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("after_hold_latency", lat, 4);
    chk("after_hold_difference", d16, 16'hFFFE);
    chk("after_hold_borrow", bo16, 1'b0);
    finish16();

    // Reset during the second RUN cycle aborts the transaction.
    iv16 = 1'b1; a16 = 16'h0000; b16 = 16'h0001; bin16 = 1'b0;
    tick();
    iv16 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_out_valid", ov16, 1'b0);
    chk("abort_in_ready", ir16, 1'b1);
    chk("abort_difference", d16, 16'h0);
    chk("abort_borrow", bo16, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov16) seen++;
    end
    chk("abort_no_out_valid", seen, 0);
    start16(16'h1234, 16'h0234, 1'b0, lat);
    chk("post_abort_latency", lat, 4);
    chk("post_abort_difference", d16, 16'h1000);
    chk("post_abort_borrow", bo16, 1'b0);
    finish16();

    // Single-digit instance: one RUN cycle.
    iv8 = 1'b1; a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0;
    tick();
    iv8 = 1'b0;
    chk("w8_not_yet_valid", ov8, 1'b0);
    tick();
    chk("w8_out_valid", ov8, 1'b1);
    chk("w8_difference", d8, 8'hF0);
    chk("w8_borrow", bo8, 1'b1);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("w8_ready_back", ir8, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
      iv8 = 1'b1; a8 = ra; b8 = rb; bin8 = rbi;
      tick();
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("rand[%0d] a=%h b=%h bin=%b", n, ra, rb, rbi),
          {lat[7:0], bo8, d8}, {8'd1, ref9[8], ref9[7:0]});
`ifdef SERIAL_SUB_FLAGS_EN
      chk($sformatf("rand_flags[%0d]", n), {z8, v8},
          {ref9[7:0] == 8'h00, (ra[7] != rb[7]) && (ref9[7] != ra[7])});
`endif
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
